// File: rtl/simd_pkg.sv
// Shared types and sizing for the vector execute stage and its lane ALU.
package simd_pkg;

  localparam int REGISTER_SIZE  = 16;
  localparam int VECTOR_SIZE    = 4;
  localparam int SELECTION_BITS = 4;
  localparam int VEC_REG_COUNT  = 4;
  localparam int LANE_BITS      = $clog2(VECTOR_SIZE);

  typedef logic [REGISTER_SIZE-1:0]                  lane_t;
  typedef logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] vec_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Indices below VEC_REG_COUNT are vector registers; the rest are scalar/special.
  function automatic logic is_vec_reg(input logic [SELECTION_BITS-1:0] idx);
    return idx < SELECTION_BITS'(VEC_REG_COUNT);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU; all arithmetic wraps modulo 2^REGISTER_SIZE.
module vec_lane_alu
  import simd_pkg::*;
(
  input  logic [REGISTER_SIZE-1:0] a,
  input  logic [REGISTER_SIZE-1:0] b,
  input  logic [2:0]               op,
  output logic [REGISTER_SIZE-1:0] res
);

  always_comb begin
    res = '0;
    case (op_e'(op))
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      // Shift amount uses only the low nibble of B.
      OP_SLL:  res = a << b[3:0];
      OP_SRL:  res = a >> b[3:0];
      OP_MUL:  res = a * b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Vector execute stage: single-cycle lane ops write back one cycle after accept;
// MUL runs one lane per cycle through lane ALU 0 and writes back after the last lane.
module vec_exec_unit
  import simd_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   inValid,
  output logic                                   inReady,
  input  logic [2:0]                             opCode,
  input  logic [SELECTION_BITS-1:0]              destReg,
  input  logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   operand1,
  input  logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   operand2,
  output logic                                   regWrEnVec,
  output logic                                   regWrEnSc,
  output logic [SELECTION_BITS-1:0]              regToWrite,
  output logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   wbData,
  output logic                                   busyValid,
  output logic [SELECTION_BITS-1:0]              busyReg
);

  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(VECTOR_SIZE - 1);

  state_e                    state_q, state_d;
  logic [LANE_BITS-1:0]      lane_cnt_q, lane_cnt_d;
  vec_t                      op_a_q, op_a_d;
  vec_t                      op_b_q, op_b_d;
  vec_t                      mul_res_q, mul_res_d;
  logic                      wr_vec_q, wr_vec_d;
  logic                      wr_sc_q, wr_sc_d;
  logic [SELECTION_BITS-1:0] reg_to_write_q, reg_to_write_d;
  vec_t                      wb_data_q, wb_data_d;
  logic                      busy_vld_q, busy_vld_d;
  logic [SELECTION_BITS-1:0] busy_reg_q, busy_reg_d;

  vec_t       op1_v, op2_v;
  vec_t       alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       accept;

  assign op1_v = operand1;
  assign op2_v = operand2;

  assign inReady = (state_q == IDLE) && !reset;
  assign accept  = inValid && inReady;

  // While a MUL is in flight, lane ALU 0 is borrowed for the serial lane.
  always_comb begin
    alu_a  = op1_v;
    alu_b  = op2_v;
    alu_op = opCode;
    if (state_q == MUL) begin
      alu_a[0] = op_a_q[lane_cnt_q];
      alu_b[0] = op_b_q[lane_cnt_q];
      alu_op   = OP_MUL;
    end
  end

  for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_lane
    vec_lane_alu u_alu (
      .a   (alu_a[i]),
      .b   (alu_b[i]),
      .op  (alu_op),
      .res (alu_res[i])
    );
  end

  always_comb begin
    state_d        = state_q;
    lane_cnt_d     = lane_cnt_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    mul_res_d      = mul_res_q;
    wr_vec_d       = 1'b0;
    wr_sc_d        = 1'b0;
    reg_to_write_d = reg_to_write_q;
    wb_data_d      = wb_data_q;
    busy_vld_d     = 1'b0;
    busy_reg_d     = busy_reg_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          busy_vld_d = 1'b1;
          busy_reg_d = destReg;
          if (op_e'(opCode) == OP_MUL) begin
            state_d    = MUL;
            lane_cnt_d = '0;
            op_a_d     = op1_v;
            op_b_d     = op2_v;
          end else begin
            wb_data_d      = alu_res;
            reg_to_write_d = destReg;
            wr_vec_d       = is_vec_reg(destReg);
            wr_sc_d        = !is_vec_reg(destReg);
          end
        end
      end
      MUL: begin
        // Busy stays up through the write-back cycle that follows the last lane.
        busy_vld_d            = 1'b1;
        mul_res_d[lane_cnt_q] = alu_res[0];
        lane_cnt_d            = lane_cnt_q + LANE_BITS'(1);
        if (lane_cnt_q == LAST_LANE) begin
          state_d        = IDLE;
          lane_cnt_d     = '0;
          wb_data_d      = mul_res_d;
          reg_to_write_d = busy_reg_q;
          wr_vec_d       = is_vec_reg(busy_reg_q);
          wr_sc_d        = !is_vec_reg(busy_reg_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      lane_cnt_q     <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      mul_res_q      <= '0;
      wr_vec_q       <= 1'b0;
      wr_sc_q        <= 1'b0;
      reg_to_write_q <= '0;
      wb_data_q      <= '0;
      busy_vld_q     <= 1'b0;
      busy_reg_q     <= '0;
    end else begin
      state_q        <= state_d;
      lane_cnt_q     <= lane_cnt_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      mul_res_q      <= mul_res_d;
      wr_vec_q       <= wr_vec_d;
      wr_sc_q        <= wr_sc_d;
      reg_to_write_q <= reg_to_write_d;
      wb_data_q      <= wb_data_d;
      busy_vld_q     <= busy_vld_d;
      busy_reg_q     <= busy_reg_d;
    end
  end

  assign regWrEnVec = wr_vec_q;
  assign regWrEnSc  = wr_sc_q;
  assign regToWrite = reg_to_write_q;
  assign wbData     = wb_data_q;
  assign busyValid  = busy_vld_q;
  assign busyReg    = busy_reg_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed bench for vec_exec_unit: hand-computed write-back values, strobe timing and handshake.
module tb_vec_exec_unit;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  opCode;
  logic [3:0]  destReg;
  logic [63:0] operand1;
  logic [63:0] operand2;
  logic        regWrEnVec;
  logic        regWrEnSc;
  logic [3:0]  regToWrite;
  logic [63:0] wbData;
  logic        busyValid;
  logic [3:0]  busyReg;

  int checks   = 0;
  int failures = 0;
  int strobes;

  vec_exec_unit dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .opCode     (opCode),
    .destReg    (destReg),
    .operand1   (operand1),
    .operand2   (operand2),
    .regWrEnVec (regWrEnVec),
    .regWrEnSc  (regWrEnSc),
    .regToWrite (regToWrite),
    .wbData     (wbData),
    .busyValid  (busyValid),
    .busyReg    (busyReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] op, input logic [3:0] dst,
                         input logic [63:0] a, input logic [63:0] b);
    inValid  = 1'b1;
    opCode   = op;
    destReg  = dst;
    operand1 = a;
    operand2 = b;
  endtask

  task automatic check_wb(input string tag, input logic vec, input logic sc,
                          input logic [3:0] idx, input logic [63:0] data);
    check({tag, "_vec"}, 64'(regWrEnVec), 64'(vec));
    check({tag, "_sc"},  64'(regWrEnSc),  64'(sc));
    check({tag, "_idx"}, 64'(regToWrite), 64'(idx));
    check({tag, "_dat"}, wbData, data);
  endtask

  initial begin
    reset    = 1'b1;
    inValid  = 1'b0;
    opCode   = 3'd0;
    destReg  = 4'd0;
    operand1 = 64'd0;
    operand2 = 64'd0;

    tick();
    tick();
    check("rst_ready", 64'(inReady), 64'd0);
    check_wb("rst", 1'b0, 1'b0, 4'd0, 64'd0);
    check("rst_busy", 64'(busyValid), 64'd0);
    check("rst_busyreg", 64'(busyReg), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(inReady), 64'd1);

    // ADD to vector register 2
    present(3'd0, 4'd2, 64'h0001_0002_0003_0004, 64'h0001_0001_0001_0001);
    tick();
    inValid = 1'b0;
    check_wb("add", 1'b1, 1'b0, 4'd2, 64'h0002_0003_0004_0005);
    check("add_busy", 64'(busyValid), 64'd1);
    check("add_busyreg", 64'(busyReg), 64'd2);
    tick();
    check_wb("add_after", 1'b0, 1'b0, 4'd2, 64'h0002_0003_0004_0005);
    check("add_after_busy", 64'(busyValid), 64'd0);

    // SUB wraps, scalar destination
    present(3'd1, 4'd5, 64'd0, 64'h0001_0001_0001_0001);
    tick();
    inValid = 1'b0;
    check_wb("sub", 1'b0, 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // MUL: lanes 0x100*0x100, 4*3, 3*3, 2*3
    present(3'd7, 4'd1, 64'h0002_0003_0004_0100, 64'h0003_0003_0003_0100);
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_ready_c%0d", i), 64'(inReady), 64'd0);
      check($sformatf("mul_busy_c%0d", i), 64'(busyValid), 64'd1);
      check($sformatf("mul_busyreg_c%0d", i), 64'(busyReg), 64'd1);
      check_wb($sformatf("mul_hold_c%0d", i), 1'b0, 1'b0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
    end
    check_wb("mul", 1'b1, 1'b0, 4'd1, 64'h0006_0009_000C_0000);
    check("mul_wb_busy", 64'(busyValid), 64'd1);
    check("mul_wb_ready", 64'(inReady), 64'd1);
    tick();
    check_wb("mul_after", 1'b0, 1'b0, 4'd1, 64'h0006_0009_000C_0000);
    check("mul_after_busy", 64'(busyValid), 64'd0);

    // Back-to-back: XOR to scalar 13, then SLL to vector 0
    present(3'd4, 4'd13, 64'h00F0_0F00_FFFF_1234, 64'h0F0F_0F0F_FFFF_0000);
    tick();
    check_wb("xor", 1'b0, 1'b1, 4'd13, 64'h0FFF_000F_0000_1234);
    present(3'd5, 4'd0, 64'h0001_0001_0001_0001, 64'h0004_0004_0004_0004);
    tick();
    inValid = 1'b0;
    check_wb("sll", 1'b1, 1'b0, 4'd0, 64'h0010_0010_0010_0010);
    check("sll_busy", 64'(busyValid), 64'd1);
    check("sll_busyreg", 64'(busyReg), 64'd0);
    tick();
    check_wb("sll_after", 1'b0, 1'b0, 4'd0, 64'h0010_0010_0010_0010);

    // AND, OR, SRL streamed; SRL lane 0 uses shift 0x10 -> low nibble 0
    present(3'd2, 4'd3, 64'hFF00_00FF_1234_FFFF, 64'h0F0F_0F0F_FFFF_0000);
    tick();
    check_wb("and", 1'b1, 1'b0, 4'd3, 64'h0F00_000F_1234_0000);
    present(3'd3, 4'd15, 64'hFF00_00FF_1234_FFFF, 64'h0F0F_0F0F_FFFF_0000);
    tick();
    check_wb("or", 1'b0, 1'b1, 4'd15, 64'hFF0F_0FFF_FFFF_FFFF);
    present(3'd6, 4'd4, 64'h8000_F000_0100_FFFF, 64'h000F_0004_0008_0010);
    tick();
    inValid = 1'b0;
    check_wb("srl", 1'b0, 1'b1, 4'd4, 64'h0001_0F00_0001_FFFF);
    tick();

    // Handshake: ADD held while MUL is busy
    present(3'd7, 4'd3, 64'h0002_0002_0002_0002, 64'h0002_0002_0002_0002);
    tick();
    present(3'd0, 4'd6, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      if (regWrEnVec || regWrEnSc) strobes++;
      tick();
    end
    check("hs_no_early_strobe", 64'(strobes), 64'd0);
    check_wb("hs_mul", 1'b1, 1'b0, 4'd3, 64'h0004_0004_0004_0004);
    tick();
    inValid = 1'b0;
    check_wb("hs_add", 1'b0, 1'b1, 4'd6, 64'h0002_0002_0002_0002);
    check("hs_add_busyreg", 64'(busyReg), 64'd6);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (regWrEnVec || regWrEnSc) strobes++;
    end
    check("hs_no_dup", 64'(strobes), 64'd0);

    // Reset two cycles into a MUL, with an ADD offered during reset
    present(3'd7, 4'd2, 64'h0005_0005_0005_0005, 64'h0005_0005_0005_0005);
    tick();
    inValid = 1'b0;
    tick();
    reset = 1'b1;
    present(3'd0, 4'd1, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
    tick();
    check_wb("rstmul", 1'b0, 1'b0, 4'd0, 64'd0);
    check("rstmul_busy", 64'(busyValid), 64'd0);
    check("rstmul_ready", 64'(inReady), 64'd0);
    inValid = 1'b0;
    reset   = 1'b0;
    #1;
    check("rstmul_ready_after", 64'(inReady), 64'd1);
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (regWrEnVec || regWrEnSc) strobes++;
    end
    check("rstmul_no_strobe", 64'(strobes), 64'd0);
    check("rstmul_busy_after", 64'(busyValid), 64'd0);
    check("rstmul_ready_end", 64'(inReady), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
